// File: rtl/alorium_lfsr_pkg.sv
// Shared definitions for the LFSR word generator: FSM encoding, step clamp
// and known maximal-length Fibonacci tap masks.
package alorium_lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        VALID = 2'd2
    } lfsr_state_t;

    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [15:0] TAPS_16 = 16'hB400;
    localparam logic [31:0] TAPS_32 = 32'h80200003;

    // Zero steps would never finish a word, and more than WIDTH adds nothing new.
    function automatic int unsigned clamp_steps(input int unsigned steps,
                                                input int unsigned width);
        if (steps == 0) begin
            return 1;
        end
        if (steps > width) begin
            return width;
        end
        return steps;
    endfunction

endpackage

// File: rtl/alorium_lfsr_hb.sv
// Liveness heartbeat: toggles after a selectable number of shift cycles.
module alorium_lfsr_hb
    import alorium_lfsr_pkg::*;
#(
    parameter int unsigned HB_SHORT = 10,
    parameter int unsigned HB_LONG  = 10000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic long_hb,
    output logic heartbeat
);

    localparam int unsigned HB_MAX = (HB_LONG > HB_SHORT) ? HB_LONG : HB_SHORT;
    localparam int unsigned CW     = $clog2(HB_MAX + 1);
    localparam logic [CW-1:0] SHORT_M1 = CW'(HB_SHORT - 1);
    localparam logic [CW-1:0] LONG_M1  = CW'(HB_LONG - 1);

    logic [CW-1:0] r_cnt;
    logic          r_hb;
    logic [CW-1:0] w_limit;

    assign w_limit   = long_hb ? LONG_M1 : SHORT_M1;
    assign heartbeat = r_hb;

    // Compare with >= so a switch to the shorter period wraps on the next shift.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_hb  <= 1'b0;
        end else if (tick) begin
            if (r_cnt >= w_limit) begin
                r_cnt <= '0;
                r_hb  <= ~r_hb;
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alorium_lfsr_gen.sv
// Programmable Fibonacci LFSR that emits one WIDTH-bit word per request
// over a valid/ready output, plus a board-level heartbeat.
module alorium_lfsr_gen
    import alorium_lfsr_pkg::*;
#(
    parameter int unsigned       WIDTH        = 16,
    parameter logic [WIDTH-1:0]  DEFAULT_TAPS = TAPS_16,
    parameter int unsigned       HB_SHORT     = 10,
    parameter int unsigned       HB_LONG      = 10000000
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic                       new_seed,
    input  logic [WIDTH-1:0]           seed,
    input  logic                       taps_we,
    input  logic [WIDTH-1:0]           taps,
    input  logic [$clog2(WIDTH+1)-1:0] steps,
    input  logic                       long_hb,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       busy,
    output logic                       heartbeat
);

    localparam int unsigned SW = $clog2(WIDTH + 1);

    lfsr_state_t      r_state;
    logic [WIDTH-1:0] r_lfsr;
    logic [WIDTH-1:0] r_taps;
    logic [SW-1:0]    r_rem;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_busy;

    logic             w_fb;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_seed;
    logic [WIDTH-1:0] w_taps_wr;
    logic [SW-1:0]    w_clamped;
    logic             w_tick;

    assign w_fb      = ^(r_lfsr & r_taps);
    assign w_next    = {r_lfsr[WIDTH-2:0], w_fb};
    assign w_seed    = (seed == '0) ? WIDTH'(1) : seed;
    assign w_taps_wr = (taps == '0) ? DEFAULT_TAPS : taps;
    assign w_clamped = SW'(clamp_steps(32'(steps), WIDTH));
    assign w_tick    = (r_state == SHIFT);

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign busy      = r_busy;

    // A reseed overrides everything else and drops any word in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_lfsr  <= WIDTH'(1);
            r_taps  <= DEFAULT_TAPS;
            r_rem   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_busy  <= 1'b0;
        end else if (new_seed) begin
            r_lfsr  <= w_seed;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
            if ((r_state == IDLE) && taps_we) begin
                r_taps <= w_taps_wr;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (taps_we) begin
                        r_taps <= w_taps_wr;
                    end
                    if (enable) begin
                        r_rem   <= w_clamped;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_lfsr <= w_next;
                    r_rem  <= r_rem - 1'b1;
                    if (r_rem == SW'(1)) begin
                        r_data  <= w_next;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= VALID;
                    end
                end
                VALID: begin
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        if (enable) begin
                            r_rem   <= w_clamped;
                            r_busy  <= 1'b1;
                            r_state <= SHIFT;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    alorium_lfsr_hb #(
        .HB_SHORT (HB_SHORT),
        .HB_LONG  (HB_LONG)
    ) u_hb (
        .clk       (clk),
        .reset_n   (reset_n),
        .tick      (w_tick),
        .long_hb   (long_hb),
        .heartbeat (heartbeat)
    );

endmodule

// File: tb/tb_alorium_lfsr_gen.sv
// Directed bench for alorium_lfsr_gen at WIDTH=8 with a word scoreboard
// fed by a bit-serial reference model.
module tb_alorium_lfsr_gen;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       new_seed;
    logic [7:0] seed;
    logic       taps_we;
    logic [7:0] taps;
    logic [3:0] steps;
    logic       long_hb;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;
    logic       heartbeat;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] expQ[$];
    logic [7:0] mLfsr;
    logic [7:0] mTaps;
    bit         sbOn;

    always #5 clk = ~clk;

    alorium_lfsr_gen #(
        .WIDTH        (8),
        .DEFAULT_TAPS (8'hB8),
        .HB_SHORT     (10),
        .HB_LONG      (20)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .new_seed  (new_seed),
        .seed      (seed),
        .taps_we   (taps_we),
        .taps      (taps),
        .steps     (steps),
        .long_hb   (long_hb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .heartbeat (heartbeat)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] modelNext(input logic [7:0] s, input logic [7:0] t);
        logic fb = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (t[i]) fb = fb ^ s[i];
        end
        return {s[6:0], fb};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushWord(input int k);
        int n = (k == 0) ? 1 : ((k > 8) ? 8 : k);
        for (int i = 0; i < n; i++) begin
            mLfsr = modelNext(mLfsr, mTaps);
        end
        expQ.push_back(mLfsr);
    endtask

    task automatic modelReset();
        mLfsr = 8'h01;
        mTaps = 8'hB8;
        expQ.delete();
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        tick();
        modelReset();
        reset_n = 1'b1;
        tick();
    endtask

    // Request one word from IDLE and wait (bounded) until it is presented.
    task automatic applyStimulus(input logic [3:0] k, output logic [7:0] obs);
        int n = 0;
        steps  = k;
        enable = 1'b1;
        pushWord(int'(k));
        tick();
        enable = 1'b0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        checkOutput("word_ready", out_valid, 1);
        obs = out_data;
        if (out_ready) tick();
    endtask

    // Scoreboard: every accepted word must match the next expected word.
    always @(negedge clk) begin
        if (sbOn && reset_n && out_valid && out_ready) begin
            checkOutput("sb_nonempty", 32'(expQ.size() != 0), 1);
            if (expQ.size() != 0) begin
                checkOutput("sb_word", out_data, expQ.pop_front());
            end
        end
    end

    initial begin
        logic [7:0] obs;
        logic [7:0] held;
        int         dup;
        int         hbCnt;
        bit         seen [256];
        logic       expHb;

        reset_n   = 1'b0;
        enable    = 1'b0;
        new_seed  = 1'b0;
        seed      = 8'h00;
        taps_we   = 1'b0;
        taps      = 8'h00;
        steps     = 4'd1;
        long_hb   = 1'b0;
        out_ready = 1'b1;
        sbOn      = 1'b1;
        modelReset();
        repeat (3) tick();

        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_data", out_data, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_hb", heartbeat, 0);
        reset_n = 1'b1;
        tick();

        $display("[TB] back-to-back single-step words");
        steps  = 4'd1;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) pushWord(1);
        for (int i = 0; i <= 8; i++) begin
            tick();
            checkOutput("tput_valid", out_valid, ((i % 2) == 1) && (i <= 7));
            checkOutput("tput_busy", busy, ((i % 2) == 0) && (i <= 6));
            if (i == 6) enable = 1'b0;
        end
        checkOutput("tput_drained", expQ.size(), 0);

        $display("[TB] asynchronous reset mid-shift");
        steps  = 4'd8;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        checkOutput("mid_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_valid", out_valid, 0);
        checkOutput("arst_data", out_data, 0);
        checkOutput("arst_hb", heartbeat, 0);
        tick();
        modelReset();
        reset_n = 1'b1;
        tick();

        $display("[TB] four-step word latency");
        steps  = 4'd4;
        enable = 1'b1;
        pushWord(4);
        for (int i = 0; i <= 4; i++) begin
            tick();
            if (i == 0) enable = 1'b0;
            checkOutput("lat_busy", busy, i <= 3);
            checkOutput("lat_valid", out_valid, i == 4);
        end
        checkOutput("lat_word", out_data, 8'h11);
        tick();

        $display("[TB] full period of single-step words");
        doReset();
        dup = 0;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        for (int w = 1; w <= 255; w++) begin
            applyStimulus(4'd1, obs);
            if (seen[obs]) dup++;
            seen[obs] = 1'b1;
        end
        checkOutput("period_word255", obs, 8'h01);
        checkOutput("period_no_repeat", dup, 0);

        $display("[TB] step clamping");
        applyStimulus(4'd0, obs);
        applyStimulus(4'd12, obs);

        $display("[TB] reseeding");
        seed     = 8'h00;
        new_seed = 1'b1;
        tick();
        new_seed = 1'b0;
        mLfsr    = 8'h01;
        applyStimulus(4'd1, obs);
        checkOutput("zero_seed_word", obs, 8'h02);

        steps  = 4'd8;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        repeat (2) tick();
        seed     = 8'h5A;
        new_seed = 1'b1;
        tick();
        new_seed = 1'b0;
        mLfsr    = 8'h5A;
        for (int i = 0; i < 10; i++) begin
            checkOutput("abort_valid", out_valid, 0);
            checkOutput("abort_busy", busy, 0);
            tick();
        end
        applyStimulus(4'd1, obs);
        checkOutput("reseed_word", obs, 8'hB4);

        $display("[TB] backpressure and tap writes");
        out_ready = 1'b0;
        applyStimulus(4'd3, held);
        taps_we = 1'b1;
        taps    = 8'h8E;
        tick();
        taps_we = 1'b0;
        for (int i = 0; i < 20; i++) begin
            checkOutput("hold_data", out_data, held);
            checkOutput("hold_valid", out_valid, 1);
            checkOutput("hold_busy", busy, 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        applyStimulus(4'd8, obs);

        seed     = 8'h33;
        new_seed = 1'b1;
        taps     = 8'h8E;
        taps_we  = 1'b1;
        tick();
        new_seed = 1'b0;
        taps_we  = 1'b0;
        mLfsr    = 8'h33;
        mTaps    = 8'h8E;
        applyStimulus(4'd8, obs);
        applyStimulus(4'd5, obs);

        taps    = 8'h00;
        taps_we = 1'b1;
        tick();
        taps_we = 1'b0;
        mTaps   = 8'hB8;
        applyStimulus(4'd8, obs);
        applyStimulus(4'd2, obs);

        $display("[TB] heartbeat periods");
        doReset();
        sbOn   = 1'b0;
        steps  = 4'd8;
        enable = 1'b1;
        hbCnt  = 0;
        expHb  = 1'b0;
        for (int i = 0; i < 230; i++) begin
            long_hb = (i >= 80) && (i < 160);
            checkOutput("hb_level", heartbeat, expHb);
            if (busy) begin
                if (hbCnt >= (long_hb ? 19 : 9)) begin
                    hbCnt = 0;
                    expHb = ~expHb;
                end else begin
                    hbCnt++;
                end
            end
            tick();
        end
        enable = 1'b0;
        for (int i = 0; i < 20 && (busy || out_valid); i++) tick();
        checkOutput("hb_idle", busy, 0);

        checkOutput("sb_drain", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
